// File: rtl/lcd_stream_pkg.sv
// Shared definitions for the LCD pixel stream FIFO: packed entry layout and a clog2 helper.
// No logic; elaboration-time constants only.
// Entry layout (MSB..LSB): {sop, eop, empty, data}.
package lcd_stream_pkg;

  // Two flag bits sit above the {empty, data} payload. Offsets are relative to the flag base.
  localparam int FLAG_BITS = 2;
  localparam int SOP_OFS   = 1;
  localparam int EOP_OFS   = 0;
  // The empty field starts immediately above the data payload.
  localparam int EMPTY_OFS = 0;

  // Ceiling log2, used to size pointers from DEPTH.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_pixel_stream_fifo_if.sv
// Avalon-ST beat bundle: data, empty, sop, eop with valid/ready.
// Pure wiring, no latency.
// master drives the beat and valid; slave returns ready (ready latency 0).
interface lcd_pixel_stream_fifo_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   startofpacket;
  logic                   endofpacket;
  logic                   valid;
  logic                   ready;

  modport master (
    output data, empty, startofpacket, endofpacket, valid,
    input  ready
  );

  modport slave (
    input  data, empty, startofpacket, endofpacket, valid,
    output ready
  );
endinterface

// File: rtl/lcd_stream_fifo_ram.sv
// Simple dual-port storage array for the pixel stream FIFO.
// Write lands at the clock edge; read is combinational at rd_addr.
// No flow control here; the caller guarantees it never overwrites live entries.
module lcd_stream_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage carries no reset: contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/lcd_pixel_stream_fifo.sv
// Avalon-ST pixel FIFO, first-word-fall-through, optional whole-packet store-and-forward.
// Beat written at edge N is visible at the source from cycle N+1; no same-cycle bypass.
// sink_ready follows the registered level, so a read frees a slot for the following cycle.
module lcd_pixel_stream_fifo
  import lcd_stream_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int EMPTY_WIDTH        = 3,
  parameter int DEPTH              = 128,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int STORE_AND_FORWARD  = 0,
  localparam int AW                = clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  lcd_pixel_stream_fifo_if.slave  avalonst_sink,
  lcd_pixel_stream_fifo_if.master avalonst_source,
  output logic [AW:0]             fill_level,
  output logic                    almost_full,
  output logic [AW:0]             packet_count
);

  localparam int         FLAG_BASE = DATA_WIDTH + EMPTY_WIDTH;
  localparam int         ENTRY_W   = FLAG_BASE + FLAG_BITS;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AF   = (AW+1)'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        fill_q, fill_d;
  logic [AW:0]        pkt_q, pkt_d;
  logic               af_q, af_d;
  logic               wr, rd, wr_eop, rd_eop;
  logic               snk_rdy, src_vld, saf_hold;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign wr_entry = {avalonst_sink.startofpacket, avalonst_sink.endofpacket,
                     avalonst_sink.empty, avalonst_sink.data};

  // Store-and-forward holds the head until a whole packet is stored, unless full
  // (a packet longer than DEPTH would otherwise never drain).
  assign saf_hold = (STORE_AND_FORWARD != 0) && (pkt_q == '0) && (fill_q != LVL_FULL);
  assign snk_rdy  = (fill_q != LVL_FULL);
  assign src_vld  = (fill_q != '0) && !saf_hold;

  assign wr     = avalonst_sink.valid & snk_rdy;
  assign rd     = src_vld & avalonst_source.ready;
  assign wr_eop = wr & wr_entry[FLAG_BASE + EOP_OFS];
  assign rd_eop = rd & rd_entry[FLAG_BASE + EOP_OFS];

  lcd_stream_fifo_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_dat  (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_entry)
  );

  // Next state of pointers, level, packet count and the almost-full flag; flush wins over rd/wr.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    pkt_d    = pkt_q;
    if (wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr && !rd)      fill_d = fill_q + LVL_ONE;
    else if (rd && !wr) fill_d = fill_q - LVL_ONE;
    if (wr_eop && !rd_eop)      pkt_d = pkt_q + LVL_ONE;
    else if (rd_eop && !wr_eop) pkt_d = pkt_q - LVL_ONE;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      pkt_d    = '0;
    end
    af_d = (fill_d >= LVL_AF);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      pkt_q    <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
      af_q     <= af_d;
    end
  end

  assign avalonst_sink.ready           = snk_rdy;
  assign avalonst_source.valid         = src_vld;
  assign avalonst_source.data          = rd_entry[DATA_WIDTH-1:0];
  assign avalonst_source.empty         = rd_entry[DATA_WIDTH + EMPTY_OFS +: EMPTY_WIDTH];
  assign avalonst_source.startofpacket = rd_entry[FLAG_BASE + SOP_OFS];
  assign avalonst_source.endofpacket   = rd_entry[FLAG_BASE + EOP_OFS];

  assign fill_level   = fill_q;
  assign packet_count = pkt_q;
  assign almost_full  = af_q;

endmodule
